// File: rtl/axi4lite_rw_scheduler_pkg.sv
// Shared definitions for the AXI4-Lite read/write scheduler: FSM state
// encoding, AXI response codes and the register-bus status mapping.
package axi4lite_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_RESPONSE = 2'd2
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // The register bus has no EXOKAY notion, so a status of 01 is reported
    // upstream as a slave error.
    function automatic logic [1:0] map_bus_status(input logic [1:0] status);
        logic [1:0] resp;
        case (status)
            2'b00:   resp = RESP_OKAY;
            2'b11:   resp = RESP_DECERR;
            default: resp = RESP_SLVERR;
        endcase
        return resp;
    endfunction

endpackage

// File: rtl/axi4lite_rw_scheduler_if.sv
// AXI4-Lite channels plus the single-outstanding register access bus.
// slave: the scheduler's view; master: the surrounding logic's view.
interface axi4lite_rw_scheduler_if #(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    localparam int ACTUAL_ID_WIDTH = (ID_WIDTH > 0) ? ID_WIDTH : 1;
    localparam int STROBE_WIDTH    = BUS_WIDTH / 8;

    logic                       i_awvalid;
    logic                       o_awready;
    logic [ACTUAL_ID_WIDTH-1:0] i_awid;
    logic [ADDRESS_WIDTH-1:0]   i_awaddr;
    logic                       i_wvalid;
    logic                       o_wready;
    logic [BUS_WIDTH-1:0]       i_wdata;
    logic [STROBE_WIDTH-1:0]    i_wstrb;
    logic                       o_bvalid;
    logic                       i_bready;
    logic [ACTUAL_ID_WIDTH-1:0] o_bid;
    logic [1:0]                 o_bresp;
    logic                       i_arvalid;
    logic                       o_arready;
    logic [ACTUAL_ID_WIDTH-1:0] i_arid;
    logic [ADDRESS_WIDTH-1:0]   i_araddr;
    logic                       o_rvalid;
    logic                       i_rready;
    logic [ACTUAL_ID_WIDTH-1:0] o_rid;
    logic [1:0]                 o_rresp;
    logic [BUS_WIDTH-1:0]       o_rdata;
    logic                       o_bus_valid;
    logic                       o_bus_write;
    logic [ADDRESS_WIDTH-1:0]   o_bus_address;
    logic [BUS_WIDTH-1:0]       o_bus_write_data;
    logic [STROBE_WIDTH-1:0]    o_bus_strobe;
    logic                       i_bus_ready;
    logic [1:0]                 i_bus_status;
    logic [BUS_WIDTH-1:0]       i_bus_read_data;

    modport slave (
        input  i_awvalid, i_awid, i_awaddr, i_wvalid, i_wdata, i_wstrb,
        input  i_bready, i_arvalid, i_arid, i_araddr, i_rready,
        input  i_bus_ready, i_bus_status, i_bus_read_data,
        output o_awready, o_wready, o_bvalid, o_bid, o_bresp,
        output o_arready, o_rvalid, o_rid, o_rresp, o_rdata,
        output o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe
    );

    modport master (
        output i_awvalid, i_awid, i_awaddr, i_wvalid, i_wdata, i_wstrb,
        output i_bready, i_arvalid, i_arid, i_araddr, i_rready,
        output i_bus_ready, i_bus_status, i_bus_read_data,
        input  o_awready, o_wready, o_bvalid, o_bid, o_bresp,
        input  o_arready, o_rvalid, o_rid, o_rresp, o_rdata,
        input  o_bus_valid, o_bus_write, o_bus_address, o_bus_write_data, o_bus_strobe
    );

endinterface

// File: rtl/axi4lite_rw_scheduler_rr_arbiter.sv
// Two-requester round-robin arbiter: on a tie, grants the requester that
// did not win last time. Last winner resets to "write" so read wins first.
module axi4lite_rr_arbiter (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_enable,
    input  logic i_req_write,
    input  logic i_req_read,
    output logic o_grant_write,
    output logic o_grant_read
);

    logic last_write;

    // Combinational grant; at most one grant, never without a request.
    always_comb begin
        o_grant_write = i_enable && i_req_write && (!i_req_read || !last_write);
        o_grant_read  = i_enable && i_req_read  && (!i_req_write || last_write);
    end

    // Remember which side won so the next tie goes the other way.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_write <= 1'b1;
        end else if (o_grant_write) begin
            last_write <= 1'b1;
        end else if (o_grant_read) begin
            last_write <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4lite_rw_scheduler.sv
// AXI4-Lite read/write scheduler: accepts one AW+W or AR transaction at a
// time, runs it on the register bus with a timeout, and returns B or R.
module axi4lite_rw_scheduler
    import axi4lite_sched_pkg::*;
#(
    parameter int ID_WIDTH       = 0,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    axi4lite_rw_scheduler_if.slave bus_if
);

    localparam int ACTUAL_ID_WIDTH = (ID_WIDTH > 0) ? ID_WIDTH : 1;
    localparam int STROBE_WIDTH    = BUS_WIDTH / 8;
    localparam int TIMER_WIDTH     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
        (TIMEOUT_CYCLES > 0) ? TIMER_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_t                     state;
    logic [TIMER_WIDTH-1:0]     timer;
    logic                       grant_write;
    logic                       grant_read;
    logic                       timer_expired;
    logic                       resp_done;

    logic [ACTUAL_ID_WIDTH-1:0] id_q;
    logic [1:0]                 resp_q;
    logic [BUS_WIDTH-1:0]       rdata_q;
    logic                       bvalid_q;
    logic                       rvalid_q;
    logic                       bus_valid_q;
    logic                       bus_write_q;
    logic [ADDRESS_WIDTH-1:0]   bus_address_q;
    logic [BUS_WIDTH-1:0]       bus_write_data_q;
    logic [STROBE_WIDTH-1:0]    bus_strobe_q;

    axi4lite_rr_arbiter u_arbiter (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_enable      (state == ST_IDLE),
        .i_req_write   (bus_if.i_awvalid && bus_if.i_wvalid),
        .i_req_read    (bus_if.i_arvalid),
        .o_grant_write (grant_write),
        .o_grant_read  (grant_read)
    );

    // Address and data are taken together so AW never lands without W.
    assign bus_if.o_awready = grant_write;
    assign bus_if.o_wready  = grant_write;
    assign bus_if.o_arready = grant_read;

    assign bus_if.o_bvalid         = bvalid_q;
    assign bus_if.o_bid            = id_q;
    assign bus_if.o_bresp          = resp_q;
    assign bus_if.o_rvalid         = rvalid_q;
    assign bus_if.o_rid            = id_q;
    assign bus_if.o_rresp          = resp_q;
    assign bus_if.o_rdata          = rdata_q;
    assign bus_if.o_bus_valid      = bus_valid_q;
    assign bus_if.o_bus_write      = bus_write_q;
    assign bus_if.o_bus_address    = bus_address_q;
    assign bus_if.o_bus_write_data = bus_write_data_q;
    assign bus_if.o_bus_strobe     = bus_strobe_q;

    // Timer counts access cycles; a zero TIMEOUT_CYCLES never expires.
    assign timer_expired = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST);
    assign resp_done     = (bvalid_q && bus_if.i_bready) || (rvalid_q && bus_if.i_rready);

    // Scheduler FSM with all bus and response outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= ST_IDLE;
            timer            <= '0;
            id_q             <= '0;
            resp_q           <= RESP_OKAY;
            rdata_q          <= '0;
            bvalid_q         <= 1'b0;
            rvalid_q         <= 1'b0;
            bus_valid_q      <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_address_q    <= '0;
            bus_write_data_q <= '0;
            bus_strobe_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timer <= '0;
                    if (grant_write) begin
                        id_q             <= bus_if.i_awid;
                        bus_write_q      <= 1'b1;
                        bus_address_q    <= bus_if.i_awaddr;
                        bus_write_data_q <= bus_if.i_wdata;
                        bus_strobe_q     <= bus_if.i_wstrb;
                        bus_valid_q      <= 1'b1;
                        state            <= ST_ACCESS;
                    end else if (grant_read) begin
                        id_q             <= bus_if.i_arid;
                        bus_write_q      <= 1'b0;
                        bus_address_q    <= bus_if.i_araddr;
                        bus_write_data_q <= '0;
                        bus_strobe_q     <= '1;
                        bus_valid_q      <= 1'b1;
                        state            <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (bus_if.i_bus_ready) begin
                        bus_valid_q <= 1'b0;
                        resp_q      <= map_bus_status(bus_if.i_bus_status);
                        if (!bus_write_q) begin
                            rdata_q <= bus_if.i_bus_read_data;
                        end
                        bvalid_q    <= bus_write_q;
                        rvalid_q    <= !bus_write_q;
                        state       <= ST_RESPONSE;
                    end else if (timer_expired) begin
                        bus_valid_q <= 1'b0;
                        resp_q      <= RESP_SLVERR;
                        if (!bus_write_q) begin
                            rdata_q <= '0;
                        end
                        bvalid_q    <= bus_write_q;
                        rvalid_q    <= !bus_write_q;
                        state       <= ST_RESPONSE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_RESPONSE: begin
                    if (resp_done) begin
                        bvalid_q <= 1'b0;
                        rvalid_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_rw_scheduler.sv
// Directed bench for axi4lite_rw_scheduler: cycle-exact stimulus applied
// after each falling edge, outputs checked 1 ns later.
module tb_axi4lite_rw_scheduler;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    axi4lite_rw_scheduler_if #(.ID_WIDTH(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) bif ();

    axi4lite_rw_scheduler #(
        .ID_WIDTH       (4),
        .ADDRESS_WIDTH  (8),
        .BUS_WIDTH      (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_if  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_n   = 1'b0;
        bif.i_awvalid = 0; bif.i_awid = 0; bif.i_awaddr = 0;
        bif.i_wvalid = 0;  bif.i_wdata = 0; bif.i_wstrb = 0;
        bif.i_bready = 0;  bif.i_arvalid = 0; bif.i_arid = 0; bif.i_araddr = 0;
        bif.i_rready = 0;  bif.i_bus_ready = 0; bif.i_bus_status = 0;
        bif.i_bus_read_data = 0;

        // Reset state
        @(negedge clk); #1;
        check("rst_bus_valid", bif.o_bus_valid, 0);
        check("rst_bvalid", bif.o_bvalid, 0);
        check("rst_rvalid", bif.o_rvalid, 0);
        check("rst_strobe", bif.o_bus_strobe, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write, bus ready two cycles after the request
        @(negedge clk);
        bif.i_awvalid = 1; bif.i_awid = 4'h3; bif.i_awaddr = 8'h10;
        bif.i_wvalid = 1; bif.i_wdata = 32'hDEADBEEF; bif.i_wstrb = 4'hF;
        #1;
        check("wr_awready", bif.o_awready, 1);
        check("wr_wready", bif.o_wready, 1);
        check("wr_arready", bif.o_arready, 0);
        @(negedge clk);
        bif.i_awvalid = 0; bif.i_wvalid = 0;
        #1;
        check("wr_bus_valid", bif.o_bus_valid, 1);
        check("wr_bus_write", bif.o_bus_write, 1);
        check("wr_bus_addr", bif.o_bus_address, 8'h10);
        check("wr_bus_data", bif.o_bus_write_data, 32'hDEADBEEF);
        check("wr_bus_strobe", bif.o_bus_strobe, 4'hF);
        check("wr_awready_busy", bif.o_awready, 0);
        @(negedge clk);
        bif.i_bus_ready = 1; bif.i_bus_status = 2'b00;
        #1;
        check("wr_bus_valid_hold", bif.o_bus_valid, 1);
        @(negedge clk);
        bif.i_bus_ready = 0;
        #1;
        check("wr_bvalid", bif.o_bvalid, 1);
        check("wr_bid", bif.o_bid, 4'h3);
        check("wr_bresp", bif.o_bresp, 2'b00);
        check("wr_bus_valid_drop", bif.o_bus_valid, 0);
        check("wr_no_rvalid", bif.o_rvalid, 0);
        @(negedge clk);
        bif.i_bready = 1;
        #1;
        check("wr_bvalid_stable", bif.o_bvalid, 1);
        @(negedge clk);
        bif.i_bready = 0;
        #1;
        check("wr_bvalid_clear", bif.o_bvalid, 0);

        // Minimum-latency read
        bif.i_arvalid = 1; bif.i_arid = 4'h1; bif.i_araddr = 8'h20;
        #1;
        check("rd_arready", bif.o_arready, 1);
        @(negedge clk);
        bif.i_arvalid = 0;
        bif.i_bus_ready = 1; bif.i_bus_read_data = 32'h12345678; bif.i_bus_status = 2'b00;
        #1;
        check("rd_bus_valid", bif.o_bus_valid, 1);
        check("rd_bus_write", bif.o_bus_write, 0);
        check("rd_bus_addr", bif.o_bus_address, 8'h20);
        check("rd_bus_strobe", bif.o_bus_strobe, 4'hF);
        @(negedge clk);
        bif.i_bus_ready = 0; bif.i_rready = 1;
        #1;
        check("rd_rvalid", bif.o_rvalid, 1);
        check("rd_rdata", bif.o_rdata, 32'h12345678);
        check("rd_rresp", bif.o_rresp, 2'b00);
        check("rd_rid", bif.o_rid, 4'h1);
        @(negedge clk);
        bif.i_rready = 0;
        #1;
        check("rd_rvalid_clear", bif.o_rvalid, 0);

        // AW without W is held off while AR proceeds; status 01 maps to SLVERR
        bif.i_awvalid = 1; bif.i_awid = 4'h2; bif.i_awaddr = 8'h30;
        bif.i_arvalid = 1; bif.i_arid = 4'h5; bif.i_araddr = 8'h40;
        #1;
        check("aw_alone_awready", bif.o_awready, 0);
        check("aw_alone_wready", bif.o_wready, 0);
        check("aw_alone_arready", bif.o_arready, 1);
        @(negedge clk);
        bif.i_arvalid = 0;
        bif.i_bus_ready = 1; bif.i_bus_read_data = 32'hA5A5A5A5; bif.i_bus_status = 2'b01;
        #1;
        check("aw_alone_awready2", bif.o_awready, 0);
        check("aw_alone_bus_addr", bif.o_bus_address, 8'h40);
        @(negedge clk);
        bif.i_bus_ready = 0; bif.i_rready = 1;
        #1;
        check("st01_rvalid", bif.o_rvalid, 1);
        check("st01_rresp", bif.o_rresp, 2'b10);
        check("st01_rid", bif.o_rid, 4'h5);
        check("st01_rdata", bif.o_rdata, 32'hA5A5A5A5);
        @(negedge clk);
        bif.i_rready = 0;
        #1;
        check("aw_alone_awready3", bif.o_awready, 0);
        @(negedge clk); #1;
        check("aw_alone_awready4", bif.o_awready, 0);
        @(negedge clk);
        bif.i_wvalid = 1; bif.i_wdata = 32'h00000011; bif.i_wstrb = 4'h3;
        #1;
        check("aw_w_awready", bif.o_awready, 1);
        check("aw_w_wready", bif.o_wready, 1);
        @(negedge clk);
        bif.i_awvalid = 0; bif.i_wvalid = 0;
        bif.i_bus_ready = 1; bif.i_bus_status = 2'b11;
        #1;
        check("aw_w_bus_write", bif.o_bus_write, 1);
        check("aw_w_bus_addr", bif.o_bus_address, 8'h30);
        check("aw_w_bus_strobe", bif.o_bus_strobe, 4'h3);
        @(negedge clk);
        bif.i_bus_ready = 0; bif.i_bready = 1;
        #1;
        check("decerr_bvalid", bif.o_bvalid, 1);
        check("decerr_bresp", bif.o_bresp, 2'b11);
        check("decerr_bid", bif.o_bid, 4'h2);
        @(negedge clk);
        bif.i_bready = 0;

        // Bus never ready: access times out after four cycles
        bif.i_arvalid = 1; bif.i_arid = 4'h7; bif.i_araddr = 8'h50;
        bif.i_bus_read_data = 32'hFFFFFFFF; bif.i_bus_status = 2'b00;
        #1;
        check("to_arready", bif.o_arready, 1);
        @(negedge clk);
        bif.i_arvalid = 0;
        #1;
        check("to_bus_valid_c1", bif.o_bus_valid, 1);
        @(negedge clk); #1;
        check("to_bus_valid_c2", bif.o_bus_valid, 1);
        @(negedge clk); #1;
        check("to_bus_valid_c3", bif.o_bus_valid, 1);
        @(negedge clk); #1;
        check("to_bus_valid_c4", bif.o_bus_valid, 1);
        check("to_no_rvalid_yet", bif.o_rvalid, 0);
        @(negedge clk);
        bif.i_rready = 1;
        #1;
        check("to_bus_valid_drop", bif.o_bus_valid, 0);
        check("to_rvalid", bif.o_rvalid, 1);
        check("to_rresp", bif.o_rresp, 2'b10);
        check("to_rdata", bif.o_rdata, 32'h0);
        check("to_rid", bif.o_rid, 4'h7);
        @(negedge clk);
        bif.i_rready = 0;

        // Asynchronous reset in the middle of an access
        bif.i_arvalid = 1; bif.i_arid = 4'h9; bif.i_araddr = 8'h60;
        #1;
        check("ar_arready", bif.o_arready, 1);
        @(negedge clk);
        bif.i_arvalid = 0;
        #1;
        check("ar_bus_valid", bif.o_bus_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_bus_valid_async", bif.o_bus_valid, 0);
        check("ar_rvalid_async", bif.o_rvalid, 0);
        check("ar_bus_addr_async", bif.o_bus_address, 0);
        @(negedge clk); #1;
        check("ar_bus_valid_held", bif.o_bus_valid, 0);
        rst_n = 1'b1;

        // All requests pending from reset: read, write, read, write
        bif.i_awvalid = 1; bif.i_awid = 4'hA; bif.i_awaddr = 8'h70;
        bif.i_wvalid = 1; bif.i_wdata = 32'hCAFEF00D; bif.i_wstrb = 4'hF;
        bif.i_arvalid = 1; bif.i_arid = 4'hB; bif.i_araddr = 8'h80;
        bif.i_bus_read_data = 32'h0BADC0DE; bif.i_bus_status = 2'b00;
        bif.i_rready = 1; bif.i_bready = 1;
        #1;
        check("rr1_arready", bif.o_arready, 1);
        check("rr1_awready", bif.o_awready, 0);
        @(negedge clk);
        bif.i_bus_ready = 1;
        #1;
        check("rr1_bus_write", bif.o_bus_write, 0);
        check("rr1_bus_addr", bif.o_bus_address, 8'h80);
        check("rr1_busy_arready", bif.o_arready, 0);
        @(negedge clk);
        bif.i_bus_ready = 0;
        #1;
        check("rr1_rvalid", bif.o_rvalid, 1);
        check("rr1_rid", bif.o_rid, 4'hB);
        check("rr1_rdata", bif.o_rdata, 32'h0BADC0DE);
        @(negedge clk); #1;
        check("rr2_awready", bif.o_awready, 1);
        check("rr2_wready", bif.o_wready, 1);
        check("rr2_arready", bif.o_arready, 0);
        @(negedge clk);
        bif.i_bus_ready = 1;
        #1;
        check("rr2_bus_write", bif.o_bus_write, 1);
        check("rr2_bus_addr", bif.o_bus_address, 8'h70);
        check("rr2_bus_data", bif.o_bus_write_data, 32'hCAFEF00D);
        @(negedge clk);
        bif.i_bus_ready = 0;
        #1;
        check("rr2_bvalid", bif.o_bvalid, 1);
        check("rr2_bid", bif.o_bid, 4'hA);
        check("rr2_bresp", bif.o_bresp, 2'b00);
        @(negedge clk); #1;
        check("rr3_arready", bif.o_arready, 1);
        check("rr3_awready", bif.o_awready, 0);
        @(negedge clk);
        bif.i_bus_ready = 1;
        #1;
        check("rr3_bus_write", bif.o_bus_write, 0);
        @(negedge clk);
        bif.i_bus_ready = 0;
        #1;
        check("rr3_rvalid", bif.o_rvalid, 1);
        @(negedge clk); #1;
        check("rr4_awready", bif.o_awready, 1);
        check("rr4_arready", bif.o_arready, 0);
        bif.i_awvalid = 0; bif.i_wvalid = 0; bif.i_arvalid = 0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/axi4lite_rw_scheduler.md
Name: axi4lite_rw_scheduler

Overview:
- Sequences AXI4-Lite traffic arriving from the skid-buffer stage onto a single-outstanding register access bus.
- Arbitrates read against write, with round-robin when both are pending.
- Holds one transaction in flight and enforces a bus timeout.
- Returns B/R responses carrying the captured ID and status.

Parameters:
- ID_WIDTH, 0: AXI ID width; actual ID ports are max(ID_WIDTH,1) bits wide (ACTUAL_ID_WIDTH).
- ADDRESS_WIDTH, 8: address width.
- BUS_WIDTH, 32: data width (32 or 64).
- TIMEOUT_CYCLES, 255: maximum cycles o_bus_valid waits for i_bus_ready; 0 disables the timeout.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, asynchronous, active-low
- i_awvalid/o_awready  in/out  1  write address handshake
- i_awid  in  ACTUAL_ID_WIDTH  write ID
- i_awaddr  in  ADDRESS_WIDTH  write address
- i_wvalid/o_wready  in/out  1  write data handshake
- i_wdata  in  BUS_WIDTH  write data
- i_wstrb  in  BUS_WIDTH/8  byte strobes
- o_bvalid/i_bready  out/in  1  write response handshake
- o_bid  out  ACTUAL_ID_WIDTH  response ID
- o_bresp  out  2  write response
- i_arvalid/o_arready  in/out  1  read address handshake
- i_arid  in  ACTUAL_ID_WIDTH  read ID
- i_araddr  in  ADDRESS_WIDTH  read address
- o_rvalid/i_rready  out/in  1  read response handshake
- o_rid  out  ACTUAL_ID_WIDTH  read ID
- o_rresp  out  2  read response
- o_rdata  out  BUS_WIDTH  read data
- o_bus_valid  out  1  register access request
- o_bus_write  out  1  1 = write, 0 = read
- o_bus_address  out  ADDRESS_WIDTH  access address
- o_bus_write_data  out  BUS_WIDTH  write data
- o_bus_strobe  out  BUS_WIDTH/8  write strobes; all ones on reads
- i_bus_ready  in  1  access complete
- i_bus_status  in  2  00 OKAY, 10 SLVERR, 11 DECERR
- i_bus_read_data  in  BUS_WIDTH  read data

Behaviour:
- Reset values: all outputs 0 except o_bus_strobe=0. FSM enters IDLE; the last-grant flag resets to "write", so the first tie goes to read.
- States: IDLE, ACCESS, RESPONSE.
- IDLE:
  - Write is eligible only when i_awvalid && i_wvalid.
  - Read is eligible when i_arvalid.
  - Only one eligible: grant it. Both eligible: grant the type opposite to the last grant.
  - Ready outputs are combinational, in IDLE only: write grant raises o_awready and o_wready together; read grant raises o_arready. Ready is never raised without the matching valid.
  - On grant, latch ID/address/data/strobe, update the last-grant flag, and go to ACCESS.
- ACCESS:
  - o_bus_valid=1 with stable payload until i_bus_ready.
  - On i_bus_ready: capture i_bus_status (01 is mapped to 10) and, for reads, i_bus_read_data; go to RESPONSE.
  - Timeout counter resets on entry. If it reaches TIMEOUT_CYCLES without i_bus_ready: drop o_bus_valid, force resp=10 (SLVERR), force rdata=0, go to RESPONSE.
- RESPONSE:
  - Assert o_bvalid or o_rvalid with stable ID/resp/data until i_bready/i_rready, then go to IDLE.
  - Next grant no earlier than the following cycle.
- Minimum latency: AR accepted cycle N, o_bus_valid N+1, i_bus_ready at N+1 gives o_rvalid at N+2; return to IDLE at N+3 if i_rready at N+2.
- Only one transaction outstanding. AW without W (or W without AW) is never accepted alone.
- Asynchronous reset mid-transaction abandons the transfer and deasserts all valids immediately.

Decomposition:
- Shared package axi4lite_sched_pkg holds:
  - state encoding (IDLE=0, ACCESS=1, RESPONSE=2);
  - RESP_OKAY/RESP_SLVERR/RESP_DECERR constants;
  - bus status-to-resp mapping function.
- One sub-module: axi4lite_rr_arbiter (2-requester round-robin, one last-grant flop).

Test Plan:
- Single write AW=0x10, W=0xDEADBEEF, strb=0xF, ID=3, bus ready after 2 cycles, status 00 → o_bus_write=1, addr=0x10; then bvalid with bid=3, bresp=00.
- Read AR=0x20, ID=1, ready same cycle, rdata=0x12345678 → o_rvalid at N+2 with rdata=0x12345678, rresp=00, rid=1.
- AW, W, and AR all pending continuously from reset → grant order read, write, read, write.
- AW valid with W held low for 5 cycles → o_awready stays 0; AR meanwhile is granted.
- TIMEOUT_CYCLES=4, i_bus_ready never → o_bus_valid drops after 4 cycles; rresp=10, rdata=0.
- Reset asserted during ACCESS → o_bus_valid/o_rvalid go to 0 asynchronously; after release the first new request is handled normally.
